// File: rtl/data_mem_responder.sv
// Data-memory responder: decodes core load/store requests onto a single-port SRAM and returns
// a single response per request.
module data_mem_responder #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_type,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [3:0] TypeNop = 4'b0000;
    localparam logic [3:0] TypeLb  = 4'b1000;
    localparam logic [3:0] TypeLh  = 4'b1001;
    localparam logic [3:0] TypeLw  = 4'b1010;
    localparam logic [3:0] TypeLbu = 4'b1011;
    localparam logic [3:0] TypeSb  = 4'b1100;
    localparam logic [3:0] TypeSh  = 4'b1101;
    localparam logic [3:0] TypeSw  = 4'b1110;
    localparam logic [3:0] TypeLhu = 4'b1111;

    typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  type_q, type_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        is_load, is_store, is_nop;
    logic        misaligned, out_of_range, fault, accept;
    logic [3:0]  store_we;
    logic [31:0] shifted;
    logic [15:0] half_sel;
    logic [31:0] load_result;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_nop     = 1'b0;
        misaligned = 1'b0;
        store_we   = 4'b0000;
        sram_wdata = req_wdata;
        unique case (req_type)
            TypeNop: is_nop = 1'b1;
            TypeLb, TypeLbu: is_load = 1'b1;
            TypeLh, TypeLhu: begin
                is_load    = 1'b1;
                misaligned = req_addr[0];
            end
            TypeLw: begin
                is_load    = 1'b1;
                misaligned = |req_addr[1:0];
            end
            TypeSb: begin
                is_store   = 1'b1;
                store_we   = 4'b0001 << req_addr[1:0];
                sram_wdata = {4{req_wdata[7:0]}};
            end
            TypeSh: begin
                is_store   = 1'b1;
                misaligned = req_addr[0];
                store_we   = req_addr[1] ? 4'b1100 : 4'b0011;
                sram_wdata = {2{req_wdata[15:0]}};
            end
            TypeSw: begin
                is_store   = 1'b1;
                misaligned = |req_addr[1:0];
                store_we   = 4'b1111;
            end
            default: ;
        endcase
    end

    // Any address bit above the SRAM's byte range means the access falls outside data space.
    assign out_of_range = |req_addr[31:ADDR_W+2];
    assign fault        = misaligned || out_of_range || !(is_load || is_store || is_nop);

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;
    assign sram_en   = accept && !fault && (is_load || is_store);
    assign sram_we   = (sram_en && is_store) ? store_we : 4'b0000;
    assign sram_addr = req_addr[ADDR_W+1:2];

    assign shifted  = sram_rdata >> {off_q, 3'b000};
    assign half_sel = off_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];

    always_comb begin
        load_result = sram_rdata;
        unique case (type_q)
            TypeLb:  load_result = {{24{shifted[7]}}, shifted[7:0]};
            TypeLbu: load_result = {24'h0, shifted[7:0]};
            TypeLh:  load_result = {{16{half_sel[15]}}, half_sel};
            TypeLhu: load_result = {16'h0, half_sel};
            default: load_result = sram_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    type_d  = req_type;
                    off_d   = req_addr[1:0];
                    rdata_d = 32'h0;
                    err_d   = fault;
                    state_d = (is_load && !fault) ? StRead : StResp;
                end
            end
            StRead: begin
                rdata_d = load_result;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            type_q  <= TypeNop;
            off_q   <= 2'b00;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: behavioural SRAM, scoreboard of expected
// responses, combinational strobe checks at accept and latency checks.
module tb_data_mem_responder;

    localparam int unsigned AW = 12;

    localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LBU = 4'b1011;
    localparam logic [3:0] SB = 4'b1100, SH = 4'b1101, SW = 4'b1110, LHU = 4'b1111;
    localparam logic [3:0] NOP = 4'b0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_type = 4'b0000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata = 32'h0;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [32:0]   exp_q [$];
    int            n_checks = 0;
    int            n_errors = 0;

    data_mem_responder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'b0000) sram_rdata <= mem[sram_addr];
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer, plus a strobe guard on every cycle that is not an accept.
    always @(negedge clk) begin
        logic [32:0] e;
        #2;
        if (!rst) begin
            if (!(req_valid && req_ready)) check("sram_en_idle", 32'(sram_en), 32'h0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e[31:0]);
                    check("rsp_err", 32'(rsp_err), 32'(e[32]));
                end
            end
        end
    end

    task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] w,
                         input logic exp_en, input logic [3:0] exp_we,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                         input logic exp_err);
        int lat;
        int exp_lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_wdata = w;
        #1;
        check("req_ready", 32'(req_ready), 32'h1);
        check("sram_en", 32'(sram_en), 32'(exp_en));
        check("sram_we", 32'(sram_we), 32'(exp_we));
        if (exp_en) check("sram_addr", 32'(sram_addr), 32'(a[AW+1:2]));
        if (exp_en && exp_we != 4'b0000) check("sram_wdata", sram_wdata, exp_wd);
        exp_q.push_back({exp_err, exp_rd});
        exp_lat = (exp_en && exp_we == 4'b0000) ? 2 : 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_type  = NOP;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("back_to_idle", 32'(req_ready), 32'h1);
    endtask

    task automatic req(input logic [3:0] t, input logic [31:0] a, input logic [31:0] w,
                       input logic exp_en, input logic [3:0] exp_we,
                       input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                       input logic exp_err);
        issue(t, a, w, exp_en, exp_we, exp_wd, exp_rd, exp_err);
        wait_idle();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_sram_en", 32'(sram_en), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_valid", 32'(rsp_valid), 32'h0);
        check("post_rst_rdata", rsp_rdata, 32'h0);
        check("post_rst_err", 32'(rsp_err), 32'h0);
        check("post_rst_ready", 32'(req_ready), 32'h1);

        // Word stores/loads
        req(SW, 32'h10, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
        req(LW, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 32'hDEADBEEF, 0);
        // Byte lane store and sign/zero-extended loads
        req(SB, 32'h13, 32'h000000A5, 1, 4'b1000, 32'hA5A5A5A5, 32'h0, 0);
        req(LB, 32'h13, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFA5, 0);
        req(LBU, 32'h13, 32'h0, 1, 4'b0000, 32'h0, 32'h000000A5, 0);
        // Halfword in upper lanes
        req(SW, 32'h20, 32'h0000CAFE, 1, 4'b1111, 32'h0000CAFE, 32'h0, 0);
        req(SH, 32'h22, 32'h00008001, 1, 4'b1100, 32'h80018001, 32'h0, 0);
        req(LH, 32'h22, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFF8001, 0);
        req(LHU, 32'h22, 32'h0, 1, 4'b0000, 32'h0, 32'h00008001, 0);
        // Lower lanes and mixed offsets
        req(SW, 32'h30, 32'h7F804012, 1, 4'b1111, 32'h7F804012, 32'h0, 0);
        req(LB, 32'h31, 32'h0, 1, 4'b0000, 32'h0, 32'h00000040, 0);
        req(LB, 32'h32, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFF80, 0);
        req(LBU, 32'h30, 32'h0, 1, 4'b0000, 32'h0, 32'h00000012, 0);
        req(LH, 32'h32, 32'h0, 1, 4'b0000, 32'h0, 32'h00007F80, 0);
        req(SH, 32'h30, 32'h0000FFFF, 1, 4'b0011, 32'hFFFFFFFF, 32'h0, 0);
        req(SB, 32'h31, 32'h00000055, 1, 4'b0010, 32'h55555555, 32'h0, 0);
        req(LW, 32'h30, 32'h0, 1, 4'b0000, 32'h0, 32'h7F8055FF, 0);
        req(LH, 32'h30, 32'h0, 1, 4'b0000, 32'h0, 32'h000055FF, 0);
        req(LB, 32'h30, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFFF, 0);
        // Last in-range word
        req(SW, 32'h3FFC, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D, 32'h0, 0);
        req(LW, 32'h3FFC, 32'h0, 1, 4'b0000, 32'h0, 32'hCAFEF00D, 0);
        req(SW, 32'h0, 32'h11223344, 1, 4'b1111, 32'h11223344, 32'h0, 0);

        // Faults never strobe the SRAM and never change its contents
        req(LW, 32'h11, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
        req(SH, 32'h23, 32'h00001234, 0, 4'b0000, 32'h0, 32'h0, 1);
        req(SW, 32'h12, 32'h99999999, 0, 4'b0000, 32'h0, 32'h0, 1);
        req(LHU, 32'h21, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
        req(LW, 32'h4000, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
        req(SB, 32'h4000, 32'h000000EE, 0, 4'b0000, 32'h0, 32'h0, 1);
        req(4'b0101, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
        req(NOP, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 0);
        req(LW, 32'h20, 32'h0, 1, 4'b0000, 32'h0, 32'h8001CAFE, 0);
        req(LW, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 32'hA5ADBEEF, 0);
        req(LW, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h11223344, 0);

        // Response backpressure
        rsp_ready = 1'b0;
        issue(LW, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 32'hA5ADBEEF, 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid), 32'h1);
            check("stall_rdata", rsp_rdata, 32'hA5ADBEEF);
            check("stall_req_ready", 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 32'(rsp_valid), 32'h0);
        check("release_req_ready", 32'(req_ready), 32'h1);
        check("release_queue", 32'(exp_q.size()), 32'h0);

        // Reset during READ drops the response
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = LW;
        req_addr  = 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_type  = NOP;
        check("read_state_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_req_ready", 32'(req_ready), 32'h0);
        check("rst_mid_sram_en", 32'(sram_en), 32'h0);
        check("rst_mid_sram_we", 32'(sram_we), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_rdata", rsp_rdata, 32'h0);
        check("rst_mid_err", 32'(rsp_err), 32'h0);
        check("rst_mid_ready", 32'(req_ready), 32'h1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_no_rsp", 32'(rsp_valid), 32'h0);
        end
        req(LW, 32'h20, 32'h0, 1, 4'b0000, 32'h0, 32'h8001CAFE, 0);

        repeat (2) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 12, meaning SRAM word-address width; data space is 4*2^ADDR_W bytes starting at byte address 0.
REQ-002 Port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, meaning synchronous active-high reset.
REQ-004 Port req_valid, input, 1, meaning the core presents a memory request.
REQ-005 Port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 Port req_type, input, 4, meaning mem_inst_type_t encoding: LB=1000, LH=1001, LW=1010, LBU=1011, SB=1100, SH=1101, SW=1110, LHU=1111, NOP=0000.
REQ-007 Port req_addr, input, 32, meaning request byte address.
REQ-008 Port req_wdata, input, 32, meaning store data, right-aligned.
REQ-009 Port rsp_valid, output, 1, meaning a response is presented.
REQ-010 Port rsp_ready, input, 1, meaning the core consumes the response.
REQ-011 Port rsp_rdata, output, 32, meaning load result, extended to 32 bits.
REQ-012 Port rsp_err, output, 1, meaning access fault: misaligned, out of range or illegal type.
REQ-013 Port sram_en, output, 1, meaning SRAM access strobe.
REQ-014 Port sram_we, output, 4, meaning per-byte write enables; 0000 means read.
REQ-015 Port sram_addr, output, ADDR_W, meaning SRAM word address, equal to req_addr[ADDR_W+1:2].
REQ-016 Port sram_wdata, output, 32, meaning lane-replicated store data.
REQ-017 Port sram_rdata, input, 32, meaning SRAM read word, valid one cycle after a read strobe.

Function
REQ-018 The FSM SHALL have three states: IDLE, READ and RESP; req_ready SHALL be 1 only in IDLE with rst=0.
REQ-019 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1.
REQ-020 A request SHALL be faulted if any of the following holds:
- LH, LHU or SH with addr[0]=1;
- LW or SW with addr[1:0]!=00;
- addr >= 4*2^ADDR_W;
- req_type in 0001..0111.
REQ-021 On accept of a non-faulted load or store, sram_en SHALL be 1 combinationally in the accept cycle; in every other cycle sram_en SHALL be 0.
REQ-022 Byte enables SHALL be as follows:
- SB: sram_we=0001<<addr[1:0];
- SH: sram_we=0011 if addr[1]=0, else 1100;
- SW: sram_we=1111;
- loads: sram_we=0000.
REQ-023 sram_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH and wdata for SW.
REQ-024 Load accept SHALL transition IDLE->READ; in READ the block SHALL capture sram_rdata, extract the result and transition to RESP.
REQ-025 Extraction SHALL use off=addr[1:0] (registered at accept) as follows:
- LB: sign-extend byte at bits 8*off+7:8*off;
- LBU: zero-extend that byte;
- LH: sign-extend half at bits 16*addr[1]+15:16*addr[1];
- LHU: zero-extend that half;
- LW: the full word.
REQ-026 Store, NOP or faulted accept SHALL transition IDLE->RESP directly with rsp_rdata=0; rsp_err=1 only when faulted.
REQ-027 Latency SHALL be: load rsp_valid rises 2 cycles after accept; store, NOP and fault rsp_valid rise 1 cycle after accept.
REQ-028 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1, then the FSM SHALL transition RESP->IDLE; no new request is accepted in that same cycle.
REQ-029 Faulted requests SHALL never modify SRAM contents.

Reset
REQ-030 rst=1 SHALL force the state to IDLE on the next edge, from any state including READ and RESP; a pending response SHALL be discarded without a handshake.
REQ-031 While rst=1, req_ready, sram_en and sram_we SHALL be 0.
REQ-032 After reset, rsp_valid=0, rsp_rdata=0x00000000, rsp_err=0 and req_ready=1 SHALL hold on the first cycle with rst=0.

Verification
REQ-033 SW addr 0x10, wdata 0xDEADBEEF -> sram_en=1, we=1111, sram_addr=4 in the accept cycle; rsp_valid next cycle, err=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF two cycles after accept.
REQ-034 SB addr 0x13, wdata 0x000000A5 -> we=1000, sram_wdata=0xA5A5A5A5. LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
REQ-035 SH addr 0x22, wdata 0x8001 -> we=1100. LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
REQ-036 LW 0x11, SH 0x23, and LW at 4*2^ADDR_W -> sram_en never asserted, rsp_err=1, rsp_rdata=0; a follow-up read shows target memory unchanged.
REQ-037 Load accepted with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; single handshake on release, then req_ready=1.
REQ-038 Load accepted, then rst=1 during READ -> next cycle IDLE, rsp_valid=0, no response ever delivered; the next request completes normally.
